// File: rtl/if_fetch_unit_if.sv
// Instruction-memory request/grant/response bus between the fetch stage and IM.
`timescale 1ns/1ps
interface if_fetch_unit_if;
  logic        im_req;
  logic [31:0] im_addr;
  logic        im_gnt;
  logic        im_rvalid;
  logic [31:0] im_rdata;

  modport master (
    output im_req,
    output im_addr,
    input  im_gnt,
    input  im_rvalid,
    input  im_rdata
  );

  modport slave (
    input  im_req,
    input  im_addr,
    output im_gnt,
    output im_rvalid,
    output im_rdata
  );
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches one instruction at a time from IM
// and holds it for IF/ID, handling redirects at any point of a fetch.
`timescale 1ns/1ps
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        Stall,
  input  logic        Redirect,
  input  logic [31:0] Redirect_PC,
  if_fetch_unit_if.master im,
  output logic [31:0] inst_out,
  output logic [31:0] PCAdd4_out,
  output logic        IM_busy
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] REQ     = 3'd1;
  localparam logic [2:0] WAIT    = 3'd2;
  localparam logic [2:0] HOLD    = 3'd3;
  localparam logic [2:0] DISCARD = 3'd4;

  logic [2:0]  state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic [31:0] pc_plus4;
  logic [31:0] redirect_tgt;
  logic [31:0] inst_nxt, pca4_nxt;

  assign redirect_tgt = Redirect_PC & 32'hFFFF_FFFC;
  assign pc_plus4     = pc + 32'd4;

  assign im.im_req  = (state == REQ);
  assign im.im_addr = pc;
  assign IM_busy    = (state != HOLD);

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    inst_nxt  = inst_out;
    pca4_nxt  = PCAdd4_out;
    unique case (state)
      IDLE: state_nxt = REQ;
      REQ: begin
        // Nothing accepted yet, so the address may still change under a redirect.
        if (Redirect) pc_nxt = redirect_tgt;
        if (im.im_gnt) state_nxt = Redirect ? DISCARD : WAIT;
      end
      WAIT: begin
        if (im.im_rvalid) begin
          if (Redirect) begin
            pc_nxt    = redirect_tgt;
            state_nxt = REQ;
          end else begin
            inst_nxt  = im.im_rdata;
            pca4_nxt  = pc_plus4;
            pc_nxt    = pc_plus4;
            state_nxt = HOLD;
          end
        end else if (Redirect) begin
          pc_nxt    = redirect_tgt;
          state_nxt = DISCARD;
        end
      end
      HOLD: begin
        if (Redirect) begin
          pc_nxt    = redirect_tgt;
          state_nxt = REQ;
        end else if (!Stall) begin
          state_nxt = REQ;
        end
      end
      DISCARD: begin
        // Stale response still owed by memory; swallow it before re-requesting.
        if (Redirect) pc_nxt = redirect_tgt;
        if (im.im_rvalid) state_nxt = REQ;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      pc         <= RESET_PC;
      inst_out   <= '0;
      PCAdd4_out <= '0;
    end else begin
      state      <= state_nxt;
      pc         <= pc_nxt;
      inst_out   <= inst_nxt;
      PCAdd4_out <= pca4_nxt;
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed self-checking bench for if_fetch_unit.
`timescale 1ns/1ps
module tb_if_fetch_unit;
  logic        clk;
  logic        rst;
  logic        Stall;
  logic        Redirect;
  logic [31:0] Redirect_PC;
  logic [31:0] inst_out;
  logic [31:0] PCAdd4_out;
  logic        IM_busy;
  int          passed;
  int          total;

  if_fetch_unit_if bus ();

  if_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk         (clk),
    .rst         (rst),
    .Stall       (Stall),
    .Redirect    (Redirect),
    .Redirect_PC (Redirect_PC),
    .im          (bus),
    .inst_out    (inst_out),
    .PCAdd4_out  (PCAdd4_out),
    .IM_busy     (IM_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b0; Stall = 1'b0; Redirect = 1'b0; Redirect_PC = '0;
    bus.im_gnt = 1'b0; bus.im_rvalid = 1'b0; bus.im_rdata = '0;
    tick; tick;
    total++; if (bus.im_req !== 1'b0) $display("FAIL rst_req: got %0b want 0", bus.im_req); else passed++;
    total++; if (bus.im_addr !== 32'h0) $display("FAIL rst_addr: got %h want 0", bus.im_addr); else passed++;
    total++; if (inst_out !== 32'h0) $display("FAIL rst_inst: got %h want 0", inst_out); else passed++;
    total++; if (PCAdd4_out !== 32'h0) $display("FAIL rst_pca4: got %h want 0", PCAdd4_out); else passed++;
    total++; if (IM_busy !== 1'b1) $display("FAIL rst_busy: got %0b want 1", IM_busy); else passed++;
    rst = 1'b1;
    tick;
    total++; if (bus.im_req !== 1'b1) $display("FAIL first_req: got %0b want 1", bus.im_req); else passed++;
    total++; if (bus.im_addr !== 32'h0) $display("FAIL first_addr: got %h want 0", bus.im_addr); else passed++;
  endtask

  task automatic test_basic_fetch;
    bus.im_gnt = 1'b1;
    tick;
    bus.im_gnt = 1'b0;
    total++; if (bus.im_req !== 1'b0) $display("FAIL basic_wait_req: got %0b want 0", bus.im_req); else passed++;
    total++; if (IM_busy !== 1'b1) $display("FAIL basic_wait_busy: got %0b want 1", IM_busy); else passed++;
    bus.im_rvalid = 1'b1; bus.im_rdata = 32'h0050_0093;
    tick;
    bus.im_rvalid = 1'b0;
    total++; if (IM_busy !== 1'b0) $display("FAIL basic_busy: got %0b want 0", IM_busy); else passed++;
    total++; if (inst_out !== 32'h0050_0093) $display("FAIL basic_inst: got %h want 00500093", inst_out); else passed++;
    total++; if (PCAdd4_out !== 32'h4) $display("FAIL basic_pca4: got %h want 4", PCAdd4_out); else passed++;
    tick;
    total++; if (bus.im_req !== 1'b1) $display("FAIL basic_next_req: got %0b want 1", bus.im_req); else passed++;
    total++; if (bus.im_addr !== 32'h4) $display("FAIL basic_next_addr: got %h want 4", bus.im_addr); else passed++;
  endtask

  task automatic test_stall;
    bus.im_gnt = 1'b1;
    tick;
    bus.im_gnt = 1'b0; bus.im_rvalid = 1'b1; bus.im_rdata = 32'h00A0_0113;
    tick;
    bus.im_rvalid = 1'b0; Stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick;
      total++; if (inst_out !== 32'h00A0_0113) $display("FAIL stall_inst[%0d]: got %h want 00a00113", i, inst_out); else passed++;
      total++; if (PCAdd4_out !== 32'h8) $display("FAIL stall_pca4[%0d]: got %h want 8", i, PCAdd4_out); else passed++;
      total++; if (IM_busy !== 1'b0) $display("FAIL stall_busy[%0d]: got %0b want 0", i, IM_busy); else passed++;
      total++; if (bus.im_req !== 1'b0) $display("FAIL stall_req[%0d]: got %0b want 0", i, bus.im_req); else passed++;
    end
    Stall = 1'b0;
    tick;
    total++; if (bus.im_req !== 1'b1) $display("FAIL stall_resume_req: got %0b want 1", bus.im_req); else passed++;
    total++; if (bus.im_addr !== 32'h8) $display("FAIL stall_resume_addr: got %h want 8", bus.im_addr); else passed++;
  endtask

  task automatic test_redirect_wait;
    bus.im_gnt = 1'b1;
    tick;
    bus.im_gnt = 1'b0; Redirect = 1'b1; Redirect_PC = 32'h0000_0103;
    tick;
    Redirect = 1'b0;
    total++; if (bus.im_req !== 1'b0) $display("FAIL rdw_req: got %0b want 0", bus.im_req); else passed++;
    total++; if (IM_busy !== 1'b1) $display("FAIL rdw_busy0: got %0b want 1", IM_busy); else passed++;
    tick;
    total++; if (bus.im_req !== 1'b0) $display("FAIL rdw_req1: got %0b want 0", bus.im_req); else passed++;
    bus.im_rvalid = 1'b1; bus.im_rdata = 32'hDEAD_BEEF;
    tick;
    bus.im_rvalid = 1'b0;
    total++; if (IM_busy !== 1'b1) $display("FAIL rdw_busy: got %0b want 1", IM_busy); else passed++;
    total++; if (inst_out !== 32'h00A0_0113) $display("FAIL rdw_inst: got %h want 00a00113", inst_out); else passed++;
    total++; if (bus.im_req !== 1'b1) $display("FAIL rdw_next_req: got %0b want 1", bus.im_req); else passed++;
    total++; if (bus.im_addr !== 32'h100) $display("FAIL rdw_next_addr: got %h want 100", bus.im_addr); else passed++;
  endtask

  task automatic test_redirect_req;
    bus.im_gnt = 1'b1; Redirect = 1'b1; Redirect_PC = 32'h0000_0200;
    tick;
    bus.im_gnt = 1'b0; Redirect = 1'b0;
    total++; if (bus.im_req !== 1'b0) $display("FAIL rdg_req: got %0b want 0", bus.im_req); else passed++;
    total++; if (bus.im_addr !== 32'h200) $display("FAIL rdg_addr: got %h want 200", bus.im_addr); else passed++;
    bus.im_rvalid = 1'b1; bus.im_rdata = 32'h1111_1111;
    tick;
    bus.im_rvalid = 1'b0;
    total++; if (bus.im_req !== 1'b1) $display("FAIL rdg_next_req: got %0b want 1", bus.im_req); else passed++;
    total++; if (bus.im_addr !== 32'h200) $display("FAIL rdg_next_addr: got %h want 200", bus.im_addr); else passed++;
    total++; if (IM_busy !== 1'b1) $display("FAIL rdg_busy: got %0b want 1", IM_busy); else passed++;
    Redirect = 1'b1; Redirect_PC = 32'h0000_0302;
    tick;
    Redirect = 1'b0;
    total++; if (bus.im_req !== 1'b1) $display("FAIL rdq_req: got %0b want 1", bus.im_req); else passed++;
    total++; if (bus.im_addr !== 32'h300) $display("FAIL rdq_addr: got %h want 300", bus.im_addr); else passed++;
  endtask

  task automatic test_redirect_hold_stall;
    bus.im_gnt = 1'b1;
    tick;
    bus.im_gnt = 1'b0; bus.im_rvalid = 1'b1; bus.im_rdata = 32'h2222_2222;
    tick;
    bus.im_rvalid = 1'b0;
    total++; if (PCAdd4_out !== 32'h304) $display("FAIL rdh_pca4: got %h want 304", PCAdd4_out); else passed++;
    Stall = 1'b1; Redirect = 1'b1; Redirect_PC = 32'h0000_0400;
    tick;
    Stall = 1'b0; Redirect = 1'b0;
    total++; if (bus.im_req !== 1'b1) $display("FAIL rdh_req: got %0b want 1", bus.im_req); else passed++;
    total++; if (bus.im_addr !== 32'h400) $display("FAIL rdh_addr: got %h want 400", bus.im_addr); else passed++;
    total++; if (IM_busy !== 1'b1) $display("FAIL rdh_busy: got %0b want 1", IM_busy); else passed++;
  endtask

  task automatic test_wrap;
    Redirect = 1'b1; Redirect_PC = 32'hFFFF_FFFC;
    tick;
    Redirect = 1'b0;
    total++; if (bus.im_addr !== 32'hFFFF_FFFC) $display("FAIL wrap_addr: got %h want fffffffc", bus.im_addr); else passed++;
    bus.im_gnt = 1'b1;
    tick;
    bus.im_gnt = 1'b0; bus.im_rvalid = 1'b1; bus.im_rdata = 32'h3333_3333;
    tick;
    bus.im_rvalid = 1'b0;
    total++; if (inst_out !== 32'h3333_3333) $display("FAIL wrap_inst: got %h want 33333333", inst_out); else passed++;
    total++; if (PCAdd4_out !== 32'h0) $display("FAIL wrap_pca4: got %h want 0", PCAdd4_out); else passed++;
    tick;
    total++; if (bus.im_req !== 1'b1) $display("FAIL wrap_next_req: got %0b want 1", bus.im_req); else passed++;
    total++; if (bus.im_addr !== 32'h0) $display("FAIL wrap_next_addr: got %h want 0", bus.im_addr); else passed++;
  endtask

  task automatic test_reset_midflight;
    Redirect = 1'b1; Redirect_PC = 32'h0000_0500;
    tick;
    Redirect = 1'b0; bus.im_gnt = 1'b1;
    tick;
    bus.im_gnt = 1'b0;
    total++; if (bus.im_addr !== 32'h500) $display("FAIL mid_pre_addr: got %h want 500", bus.im_addr); else passed++;
    #2 rst = 1'b0;
    #1;
    total++; if (bus.im_req !== 1'b0) $display("FAIL mid_rst_req: got %0b want 0", bus.im_req); else passed++;
    total++; if (bus.im_addr !== 32'h0) $display("FAIL mid_rst_addr: got %h want 0", bus.im_addr); else passed++;
    total++; if (inst_out !== 32'h0) $display("FAIL mid_rst_inst: got %h want 0", inst_out); else passed++;
    total++; if (PCAdd4_out !== 32'h0) $display("FAIL mid_rst_pca4: got %h want 0", PCAdd4_out); else passed++;
    total++; if (IM_busy !== 1'b1) $display("FAIL mid_rst_busy: got %0b want 1", IM_busy); else passed++;
    tick;
    rst = 1'b1; bus.im_rvalid = 1'b1; bus.im_rdata = 32'hBAD0_BAD0;
    tick;
    total++; if (IM_busy !== 1'b1) $display("FAIL mid_stale_busy: got %0b want 1", IM_busy); else passed++;
    total++; if (bus.im_req !== 1'b1) $display("FAIL mid_restart_req: got %0b want 1", bus.im_req); else passed++;
    total++; if (bus.im_addr !== 32'h0) $display("FAIL mid_restart_addr: got %h want 0", bus.im_addr); else passed++;
    tick;
    bus.im_rvalid = 1'b0;
    total++; if (IM_busy !== 1'b1) $display("FAIL mid_stale2_busy: got %0b want 1", IM_busy); else passed++;
    total++; if (inst_out !== 32'h0) $display("FAIL mid_stale_inst: got %h want 0", inst_out); else passed++;
    bus.im_gnt = 1'b1;
    tick;
    bus.im_gnt = 1'b0; bus.im_rvalid = 1'b1; bus.im_rdata = 32'h4444_4444;
    tick;
    bus.im_rvalid = 1'b0;
    total++; if (inst_out !== 32'h4444_4444) $display("FAIL mid_fetch_inst: got %h want 44444444", inst_out); else passed++;
    total++; if (PCAdd4_out !== 32'h4) $display("FAIL mid_fetch_pca4: got %h want 4", PCAdd4_out); else passed++;
  endtask

  initial begin
    passed = 0;
    total  = 0;
    test_reset;
    test_basic_fetch;
    test_stall;
    test_redirect_wait;
    test_redirect_req;
    test_redirect_hold_stall;
    test_wrap;
    test_reset_midflight;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
